census_transform: RTL and testbench

- Front-end stage of the stereo pipeline. Converts a raster stream of 8-bit grey pixels into a 24-bit 5x5 census signature and an 8-bit local gradient magnitude per pixel.
- Two instances, one per camera, drive the disparity stage's a/b census inputs. The left instance also supplies aGrad.
- Internal line buffers hold 4 previous rows. A 5x5 window register is built from them; census and gradient are computed from the window centre.

---
 rtl/census_transform.sv | 176 +++++++++++++++++
 tb/tb_census_transform.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/census_transform.sv
// 5x5 census signature and gradient magnitude over a raster pixel stream, 2-clk latency.
// Define GRAD_SOBEL_EN to use a 3x3 Sobel gradient instead of central differences.
module census_transform #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    ipix,
    input  logic [XW-1:0] ix,
    input  logic [XW-1:0] iy,
    input  logic          ivalid,
    output logic [23:0]   ocensus,
    output logic [7:0]    ograd,
    output logic [XW-1:0] ox,
    output logic [XW-1:0] oy,
    output logic          ovalid
);

    localparam int          AW    = $clog2(IMG_W);
    localparam logic [XW-1:0] W_LIM = XW'(IMG_W);
    localparam logic [XW-1:0] H_LIM = XW'(IMG_H);
`ifdef GRAD_SOBEL_EN
    localparam int GW = 12;
`else
    localparam int GW = 10;
`endif

    logic [7:0]    lb_mem [4][IMG_W];
    logic [7:0]    win_q [5][5];
    logic [7:0]    win_d [5][5];
    logic          sync_q, sync_d;
    logic [1:0]    row_ptr_q, row_ptr_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_full_q, s1_full_d;
    logic [XW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [23:0]   ocensus_q, ocensus_d;
    logic [7:0]    ograd_q, ograd_d;
    logic [XW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic          ovalid_q, ovalid_d;

    logic          frame_start, accept;
    logic [AW-1:0] col_a;
    logic [7:0]    lb_col [4];
    logic [23:0]   cen;
    logic [4:0]    bit_idx;
    logic [GW-1:0] pos_x, neg_x, pos_y, neg_y;
    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0] ax, ay;
    logic [GW:0]   mag, scaled;
    logic [7:0]    grad;

    assign col_a = ix[AW-1:0];

    // Stage 1: sync, row pointer, line-buffer read and window shift.
    // Slot row_ptr_d holds row y-4 until this sample overwrites it.
    always_comb begin
        frame_start = ivalid && (ix == '0) && (iy == '0);
        accept      = ivalid && (ix < W_LIM) && (iy < H_LIM) && (sync_q || frame_start);
        sync_d      = sync_q || frame_start;
        row_ptr_d   = row_ptr_q;
        if (accept && ix == '0)
            row_ptr_d = (iy == '0) ? 2'd0 : row_ptr_q + 2'd1;
        for (int k = 0; k < 4; k++)
            lb_col[k] = lb_mem[row_ptr_d - 2'(k + 1)][col_a];
        win_d      = win_q;
        s1_valid_d = 1'b0;
        s1_full_d  = s1_full_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        if (accept) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 4; c++)
                    win_d[r][c] = win_q[r][c+1];
            win_d[0][4] = lb_col[3];
            win_d[1][4] = lb_col[2];
            win_d[2][4] = lb_col[1];
            win_d[3][4] = lb_col[0];
            win_d[4][4] = ipix;
            s1_valid_d  = (ix >= XW'(2)) && (iy >= XW'(2));
            s1_full_d   = (ix >= XW'(4)) && (iy >= XW'(4));
            s1_x_d      = ix - XW'(2);
            s1_y_d      = iy - XW'(2);
        end
    end

    // Stage 2: census and gradient of the registered window.
    always_comb begin
        cen     = '0;
        bit_idx = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (!(r == 2 && c == 2)) begin
                    bit_idx      = 5'(r * 5 + c - ((r * 5 + c > 12) ? 1 : 0));
                    cen[bit_idx] = win_q[r][c] < win_q[2][2];
                end
`ifdef GRAD_SOBEL_EN
        pos_x = GW'(win_q[1][3]) + (GW'(win_q[2][3]) << 1) + GW'(win_q[3][3]);
        neg_x = GW'(win_q[1][1]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[3][1]);
        pos_y = GW'(win_q[3][1]) + (GW'(win_q[3][2]) << 1) + GW'(win_q[3][3]);
        neg_y = GW'(win_q[1][1]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[1][3]);
`else
        pos_x = GW'(win_q[2][3]);
        neg_x = GW'(win_q[2][1]);
        pos_y = GW'(win_q[3][2]);
        neg_y = GW'(win_q[1][2]);
`endif
        gx  = $signed(pos_x) - $signed(neg_x);
        gy  = $signed(pos_y) - $signed(neg_y);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = {1'b0, ax} + {1'b0, ay};
`ifdef GRAD_SOBEL_EN
        scaled = mag >> 2;
`else
        scaled = mag;
`endif
        grad = (scaled > (GW+1)'(255)) ? 8'hFF : scaled[7:0];

        ovalid_d  = s1_valid_q;
        ocensus_d = ocensus_q;
        ograd_d   = ograd_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        if (s1_valid_q) begin
            ocensus_d = s1_full_q ? cen  : '0;
            ograd_d   = s1_full_q ? grad : '0;
            ox_d      = s1_x_q;
            oy_d      = s1_y_q;
        end
    end

    always_ff @(posedge clk)
        if (accept)
            lb_mem[row_ptr_d][col_a] <= ipix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    win_q[r][c] <= '0;
            sync_q     <= 1'b0;
            row_ptr_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_full_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            ocensus_q  <= '0;
            ograd_q    <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            ovalid_q   <= 1'b0;
        end else begin
            win_q      <= win_d;
            sync_q     <= sync_d;
            row_ptr_q  <= row_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_full_q  <= s1_full_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            ocensus_q  <= ocensus_d;
            ograd_q    <= ograd_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            ovalid_q   <= ovalid_d;
        end
    end

    assign ocensus = ocensus_q;
    assign ograd   = ograd_q;
    assign ox      = ox_q;
    assign oy      = oy_q;
    assign ovalid  = ovalid_q;

endmodule

// File: tb/tb_census_transform.sv
// Directed bench for census_transform on a small frame; expected values from
// hand-computed constants and a pixel-image reference model.
module tb_census_transform;

    localparam int W  = 16;
    localparam int H  = 14;
    localparam int XW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    ipix = '0;
    logic [XW-1:0] ix = '0, iy = '0;
    logic          ivalid = 1'b0;
    logic [23:0]   ocensus;
    logic [7:0]    ograd;
    logic [XW-1:0] ox, oy;
    logic          ovalid;

    census_transform #(.IMG_W(W), .IMG_H(H), .XW(XW)) dut (
        .clk(clk), .rst_n(rst_n), .ipix(ipix), .ix(ix), .iy(iy), .ivalid(ivalid),
        .ocensus(ocensus), .ograd(ograd), .ox(ox), .oy(oy), .ovalid(ovalid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int          img   [H][W];
    logic [23:0] cap_c [H][W];
    logic [7:0]  cap_g [H][W];
    int          cap_n [H][W];
    logic [23:0] sv_c  [H][W];
    logic [7:0]  sv_g  [H][W];
    int          n_out, n_oob, lat_bad, got_first;
    int          first_x, first_y;
    logic [23:0] first_c;
    logic [7:0]  first_g;
    int          exp_q[$];
    bit          track = 1'b0;

`ifdef GRAD_SOBEL_EN
    localparam int BRIGHT_NB_GRAD = 75;
`else
    localparam int BRIGHT_NB_GRAD = 150;
`endif

    always @(negedge clk) begin
        if (ovalid) begin
            if (ox < W - 2 && oy < H - 2) begin
                cap_c[oy][ox] = ocensus;
                cap_g[oy][ox] = ograd;
                cap_n[oy][ox] = cap_n[oy][ox] + 1;
            end else
                n_oob++;
            n_out++;
            if (got_first == 0) begin
                got_first = 1;
                first_x = int'(ox);
                first_y = int'(oy);
                first_c = ocensus;
                first_g = ograd;
            end
            if (exp_q.size() == 0) lat_bad++;
            else if (exp_q.pop_front() + 1 != cyc) lat_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] m_census(int cx, int cy);
        logic [23:0] res = '0;
        int idx;
        if (cx < 2 || cy < 2) return '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                idx = r * 5 + c;
                if (idx != 12)
                    res[(idx < 12) ? idx : idx - 1] = img[cy-2+r][cx-2+c] < img[cy][cx];
            end
        return res;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [7:0] m_grad(int cx, int cy);
        int gx, gy, s;
        if (cx < 2 || cy < 2) return '0;
`ifdef GRAD_SOBEL_EN
        gx = img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1]
           - img[cy-1][cx-1] - 2*img[cy][cx-1] - img[cy+1][cx-1];
        gy = img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1]
           - img[cy-1][cx-1] - 2*img[cy-1][cx] - img[cy-1][cx+1];
        s = (iabs(gx) + iabs(gy)) >> 2;
`else
        gx = img[cy][cx+1] - img[cy][cx-1];
        gy = img[cy+1][cx] - img[cy-1][cx];
        s = iabs(gx) + iabs(gy);
`endif
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    task automatic clear_cap();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                cap_c[y][x] = '0;
                cap_g[y][x] = '0;
                cap_n[y][x] = 0;
            end
        n_out = 0; n_oob = 0; lat_bad = 0; got_first = 0;
        exp_q.delete();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            ivalid = 1'b0;
        end
    endtask

    task automatic send(int x, int y, int p);
        @(posedge clk); #1;
        ivalid = 1'b1;
        ix     = XW'(x);
        iy     = XW'(y);
        ipix   = 8'(p);
        if (track && x >= 2 && y >= 2) exp_q.push_back(cyc + 1);
    endtask

    task automatic run_rows(int y0, int y1, int maxgap);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < W; x++) begin
                if (maxgap > 0) idle($urandom_range(0, maxgap));
                send(x, y, img[y][x]);
            end
        idle(5);
    endtask

    task automatic check_frame(string tag);
        for (int y = 0; y < H - 2; y++)
            for (int x = 0; x < W - 2; x++) begin
                chk($sformatf("%s_n(%0d,%0d)", tag, x, y), cap_n[y][x], 1);
                chk($sformatf("%s_census(%0d,%0d)", tag, x, y), cap_c[y][x], m_census(x, y));
                chk($sformatf("%s_grad(%0d,%0d)", tag, x, y), cap_g[y][x], m_grad(x, y));
            end
        chk({tag, "_count"}, n_out, (W - 2) * (H - 2));
        chk({tag, "_edge_centres"}, n_oob, 0);
        chk({tag, "_latency"}, lat_bad, 0);
    endtask

    initial begin
        int diffs;
        // Reset held with a valid mid-frame sample on the inputs
        ivalid = 1'b1; ix = XW'(5); iy = XW'(7); ipix = 8'd9;
        clear_cap();
        repeat (3) @(negedge clk);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_ocensus", ocensus, 0);
        chk("rst_ograd", ograd, 0);
        chk("rst_ox", ox, 0);
        chk("rst_oy", oy, 0);
        rst_n = 1'b1;
        repeat (20) send($urandom_range(1, W - 1), $urandom_range(0, H - 1), 77);
        send(0, 3, 77);
        idle(4);
        chk("unsynced_no_output", n_out, 0);

        // Flat frame; also first output after sync
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 100;
        clear_cap(); track = 1'b1;
        run_rows(0, H - 1, 0);
        chk("first_ox", first_x, 0);
        chk("first_oy", first_y, 0);
        chk("first_census", first_c, 0);
        chk("first_grad", first_g, 0);
        chk("flat_census_8_8", cap_c[8][8], 24'h000000);
        check_frame("flat");

        // Single bright pixel
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 50;
        img[10][10] = 200;
        clear_cap();
        run_rows(0, H - 1, 0);
        chk("bright_census_c", cap_c[10][10], 24'hFFFFFF);
        chk("bright_grad_c", cap_g[10][10], 0);
        chk("bright_census_r", cap_c[10][11], 24'h000000);
        chk("bright_grad_r", cap_g[10][11], BRIGHT_NB_GRAD);
        check_frame("bright");

        // Horizontal ramp, gap-free then with random stalls
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = x;
        clear_cap();
        run_rows(0, H - 1, 0);
        chk("ramp_census_8_8", cap_c[8][8], 24'h18CC63);
        chk("ramp_grad_8_8", cap_g[8][8], 2);
        check_frame("ramp");
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin
            sv_c[y][x] = cap_c[y][x];
            sv_g[y][x] = cap_g[y][x];
        end
        clear_cap();
        run_rows(0, H - 1, 5);
        check_frame("ramp_gaps");
        diffs = 0;
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++)
            if (sv_c[y][x] !== cap_c[y][x] || sv_g[y][x] !== cap_g[y][x]) diffs++;
        chk("gap_vs_nogap", diffs, 0);

        // Gradient saturation
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 128;
        img[6][5] = 0; img[6][7] = 255; img[5][6] = 0; img[7][6] = 255;
        clear_cap();
        run_rows(0, H - 1, 2);
        chk("sat_grad", cap_g[6][6], 255);
        chk("sat_census", cap_c[6][6], 24'h000880);
        check_frame("sat");

        // Reset mid-frame: nothing emitted until the next frame start
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x * 7 + y * 13) % 256;
        track = 1'b0;
        run_rows(0, 5, 0);
        @(posedge clk); #1; rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        clear_cap();
        run_rows(6, H - 1, 0);
        chk("midreset_no_output", n_out, 0);
        clear_cap(); track = 1'b1;
        run_rows(0, H - 1, 1);
        check_frame("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
